kn_sub_pipe: RTL and testbench



---
 rtl/kn_sub_pipe_if.sv | 32 +++
 rtl/kn_sub_pipe.sv | 127 ++++++++++++
 tb/tb_kn_sub_pipe.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/kn_sub_pipe_if.sv
// Valid/ready stream bundle for kn_sub_pipe; out_ovf exists only when KN_SUB_OVF_EN is defined.
interface kn_sub_pipe_if #(
    parameter int WIDTH = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_diff;
    logic             out_borrow;
`ifdef KN_SUB_OVF_EN
    logic             out_ovf;
`endif

    modport master (
        output in_valid, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_diff, out_borrow
`ifdef KN_SUB_OVF_EN
        , input out_ovf
`endif
    );

    modport slave (
        input  in_valid, in_a, in_b, out_ready,
        output in_ready, out_valid, out_diff, out_borrow
`ifdef KN_SUB_OVF_EN
        , output out_ovf
`endif
    );
endinterface

// File: rtl/kn_sub_pipe.sv
// Two-stage Kogge-Stone subtractor (a + ~b + 1) behind a valid/ready handshake.
// Define KN_SUB_OVF_EN to add the registered signed-overflow output out_ovf.
module kn_sub_pipe #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    kn_sub_pipe_if.slave  bus
);
    localparam int LEVELS = $clog2(WIDTH);
    localparam int MID    = (LEVELS + 1) / 2;

    logic             r_s1V;
    logic             r_s2V;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_G;
    logic [WIDTH-1:0] r_P;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;

    logic             w_s1Adv;
    logic             w_s2Adv;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_G;
    logic [WIDTH-1:0] w_P;
    logic [WIDTH-1:0] w_G2;
    logic [WIDTH-1:0] w_P2;
    logic [WIDTH-1:0] w_carry;
    logic [WIDTH-1:0] w_diff;
    logic             w_borrow;

    assign w_s2Adv     = ~r_s2V | bus.out_ready;
    assign w_s1Adv     = ~r_s1V | w_s2Adv;
    assign bus.in_ready = w_s1Adv;

    // Lower half of the prefix tree; the constant carry-in of 1 is folded into bit 0.
    always_comb begin
        w_p    = bus.in_a ^ ~bus.in_b;
        w_G    = bus.in_a & ~bus.in_b;
        w_G[0] = w_G[0] | w_p[0];
        w_P    = w_p;
        for (int k = 0; k < MID; k++) begin
            for (int i = WIDTH - 1; i >= (1 << k); i--) begin
                w_G[i] = w_G[i] | (w_P[i] & w_G[i - (1 << k)]);
                w_P[i] = w_P[i] & w_P[i - (1 << k)];
            end
        end
    end

    always_comb begin
        w_G2 = r_G;
        w_P2 = r_P;
        for (int k = MID; k < LEVELS; k++) begin
            for (int i = WIDTH - 1; i >= (1 << k); i--) begin
                w_G2[i] = w_G2[i] | (w_P2[i] & w_G2[i - (1 << k)]);
                w_P2[i] = w_P2[i] & w_P2[i - (1 << k)];
            end
        end
        w_carry  = {w_G2[WIDTH-2:0], 1'b1};
        w_diff   = r_p ^ w_carry;
        w_borrow = ~w_G2[WIDTH-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1V <= 1'b0;
            r_p   <= '0;
            r_G   <= '0;
            r_P   <= '0;
        end else if (w_s1Adv) begin
            r_s1V <= bus.in_valid;
            if (bus.in_valid) begin
                r_p <= w_p;
                r_G <= w_G;
                r_P <= w_P;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s2V    <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
        end else if (w_s2Adv) begin
            r_s2V <= r_s1V;
            if (r_s1V) begin
                r_diff   <= w_diff;
                r_borrow <= w_borrow;
            end
        end
    end

    assign bus.out_valid  = r_s2V;
    assign bus.out_diff   = r_diff;
    assign bus.out_borrow = r_borrow;

`ifdef KN_SUB_OVF_EN
    // Operand sign bits ride along with stage 1 so overflow can be judged against the final diff.
    logic r_aMsb;
    logic r_bMsb;
    logic r_ovf;
    logic w_ovf;

    assign w_ovf = (r_aMsb != r_bMsb) & (w_diff[WIDTH-1] != r_aMsb);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aMsb <= 1'b0;
            r_bMsb <= 1'b0;
        end else if (w_s1Adv && bus.in_valid) begin
            r_aMsb <= bus.in_a[WIDTH-1];
            r_bMsb <= bus.in_b[WIDTH-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_s2Adv && r_s1V) begin
            r_ovf <= w_ovf;
        end
    end

    assign bus.out_ovf = r_ovf;
`endif
endmodule

// File: tb/tb_kn_sub_pipe.sv
// Bench for kn_sub_pipe: vector table, hand-written stall/reset sequences and a randomized stream
// checked against an arithmetic reference model. Honors KN_SUB_OVF_EN.
module tb_kn_sub_pipe;
    localparam int W    = 4;
    localparam int FULL = 1 << W;
    localparam int HALF = 1 << (W - 1);

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] expDiff;
        logic         expBorrow;
        logic         expOvf;
    } vec_t;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    kn_sub_pipe_if #(.WIDTH(W)) busIf ();

    kn_sub_pipe #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busIf.slave)
    );

    int     nVectors    = 0;
    int     nMiscompares = 0;
    int     delivered   = 0;
    exp_t   sbQ[$];
    logic   prevStall   = 1'b0;
    logic [W-1:0] prevDiff;
    logic   prevBorrow;
    logic   prevOvf;
    vec_t   vecs[9];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic getOvf();
`ifdef KN_SUB_OVF_EN
        return busIf.out_ovf;
`else
        return 1'b0;
`endif
    endfunction

    // Reference: plain integer arithmetic on the unsigned and signed readings of the operands.
    function automatic exp_t refModel(int a, int b);
        exp_t r;
        int d, sa, sb, sd;
        d  = a - b;
        if (d < 0) d += FULL;
        r.diff   = d[W-1:0];
        r.borrow = (a < b);
        sa = (a >= HALF) ? a - FULL : a;
        sb = (b >= HALF) ? b - FULL : b;
        sd = sa - sb;
        r.ovf = (sd < -HALF) || (sd >= HALF);
        return r;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic r);
        exp_t e;
        @(negedge clk);
        busIf.in_valid  = v;
        busIf.in_a      = a;
        busIf.in_b      = b;
        busIf.out_ready = r;
        #1;
        if (prevStall) begin
            checkOutput("holdValid", 32'(busIf.out_valid), 32'd1);
            checkOutput("holdDiff", 32'(busIf.out_diff), 32'(prevDiff));
            checkOutput("holdBorrow", 32'(busIf.out_borrow), 32'(prevBorrow));
`ifdef KN_SUB_OVF_EN
            checkOutput("holdOvf", 32'(getOvf()), 32'(prevOvf));
`endif
        end
        prevStall  = busIf.out_valid && !busIf.out_ready;
        prevDiff   = busIf.out_diff;
        prevBorrow = busIf.out_borrow;
        prevOvf    = getOvf();
        if (busIf.out_valid && busIf.out_ready) begin
            delivered++;
            if (sbQ.size() == 0) begin
                checkOutput("unexpectedOutput", 32'd1, 32'd0);
            end else begin
                e = sbQ.pop_front();
                checkOutput("sbDiff", 32'(busIf.out_diff), 32'(e.diff));
                checkOutput("sbBorrow", 32'(busIf.out_borrow), 32'(e.borrow));
`ifdef KN_SUB_OVF_EN
                checkOutput("sbOvf", 32'(getOvf()), 32'(e.ovf));
`endif
            end
        end
        if (busIf.in_valid && busIf.in_ready)
            sbQ.push_back(refModel(int'(a), int'(b)));
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst_n = 1'b0;
        busIf.in_valid  = 1'b0;
        busIf.out_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sbQ.delete();
        prevStall = 1'b0;
        checkOutput("rstValid", 32'(busIf.out_valid), 32'd0);
        checkOutput("rstDiff", 32'(busIf.out_diff), 32'd0);
        checkOutput("rstBorrow", 32'(busIf.out_borrow), 32'd0);
        checkOutput("rstInReady", 32'(busIf.in_ready), 32'd1);
`ifdef KN_SUB_OVF_EN
        checkOutput("rstOvf", 32'(getOvf()), 32'd0);
`endif
    endtask

    task automatic drainPipe();
        int n = 0;
        while (sbQ.size() != 0 && n < 20) begin
            applyStimulus(1'b0, '0, '0, 1'b1);
            n++;
        end
        checkOutput("drainEmpty", 32'(sbQ.size()), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("noExtraOutput", 32'(busIf.out_valid), 32'd0);
    endtask

    initial begin
        int startDel;
        rst_n           = 1'b0;
        busIf.in_valid  = 1'b0;
        busIf.in_a      = '0;
        busIf.in_b      = '0;
        busIf.out_ready = 1'b0;

        vecs[0] = '{4'd9,  4'd3,  4'd6,  1'b0, 1'b1};
        vecs[1] = '{4'd3,  4'd9,  4'hA,  1'b1, 1'b1};
        vecs[2] = '{4'd0,  4'd0,  4'd0,  1'b0, 1'b0};
        vecs[3] = '{4'd0,  4'd15, 4'd1,  1'b1, 1'b0};
        vecs[4] = '{4'd15, 4'd15, 4'd0,  1'b0, 1'b0};
        vecs[5] = '{4'd8,  4'd1,  4'd7,  1'b0, 1'b1};
        vecs[6] = '{4'd7,  4'hF,  4'd8,  1'b1, 1'b1};
        vecs[7] = '{4'd5,  4'd2,  4'd3,  1'b0, 1'b0};
        vecs[8] = '{4'd15, 4'd0,  4'hF,  1'b0, 1'b0};

        resetDut();

        // Table: single transaction each, checks latency and constant results.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b1, vecs[i].a, vecs[i].b, 1'b1);
            checkOutput("tblAccept", 32'(busIf.in_ready), 32'd1);
            applyStimulus(1'b0, '0, '0, 1'b1);
            checkOutput("tblEarly", 32'(busIf.out_valid), 32'd0);
            applyStimulus(1'b0, '0, '0, 1'b1);
            checkOutput("tblValid", 32'(busIf.out_valid), 32'd1);
            checkOutput("tblDiff", 32'(busIf.out_diff), 32'(vecs[i].expDiff));
            checkOutput("tblBorrow", 32'(busIf.out_borrow), 32'(vecs[i].expBorrow));
`ifdef KN_SUB_OVF_EN
            checkOutput("tblOvf", 32'(getOvf()), 32'(vecs[i].expOvf));
`endif
        end

        // Back-to-back stream of 8 with out_ready held high.
        startDel = delivered;
        for (int c = 0; c < 12; c++) begin
            applyStimulus(c < 8, W'($urandom), W'($urandom), 1'b1);
            checkOutput("streamInReady", 32'(busIf.in_ready), 32'd1);
            checkOutput("streamValid", 32'(busIf.out_valid), 32'((c >= 2) && (c <= 9)));
        end
        checkOutput("streamCount", 32'(delivered - startDel), 32'd8);
        drainPipe();

        // Stall: three offered with out_ready low, only two fit.
        startDel = delivered;
        applyStimulus(1'b1, 4'd12, 4'd5, 1'b0);
        checkOutput("stallAcc0", 32'(busIf.in_ready), 32'd1);
        applyStimulus(1'b1, 4'd2, 4'd7, 1'b0);
        checkOutput("stallAcc1", 32'(busIf.in_ready), 32'd1);
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b1, 4'd6, 4'd6, 1'b0);
            checkOutput("stallBlock", 32'(busIf.in_ready), 32'd0);
        end
        applyStimulus(1'b1, 4'd6, 4'd6, 1'b1);
        checkOutput("stallRelease", 32'(busIf.in_ready), 32'd1);
        drainPipe();
        checkOutput("stallDelivered", 32'(delivered - startDel), 32'd3);

        // Reset with both stages full, then recovery.
        applyStimulus(1'b1, 4'd1, 4'd2, 1'b0);
        applyStimulus(1'b1, 4'd3, 4'd4, 1'b0);
        applyStimulus(1'b1, 4'd5, 4'd6, 1'b0);
        checkOutput("fullInReady", 32'(busIf.in_ready), 32'd0);
        resetDut();
        applyStimulus(1'b1, 4'd9, 4'd3, 1'b1);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("postRstEarly", 32'(busIf.out_valid), 32'd0);
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("postRstValid", 32'(busIf.out_valid), 32'd1);
        checkOutput("postRstDiff", 32'(busIf.out_diff), 32'd6);
        checkOutput("postRstBorrow", 32'(busIf.out_borrow), 32'd0);
        drainPipe();

        // Randomized traffic with random backpressure.
        for (int c = 0; c < 400; c++) begin
            applyStimulus(1'($urandom_range(0, 1)), W'($urandom), W'($urandom),
                          $urandom_range(0, 3) != 0);
        end
        drainPipe();

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end
endmodule
